// File: rtl/gpio_bcd_display.sv
// gpio_bcd_display: converts the CPU GPIO output value to decimal with a
// sequential double-dabble engine and drives eight active-low seven-segment
// digits (gfedcba). Re-converts whenever the GPIO value changes and flags
// values that need more than eight decimal digits.
module gpio_bcd_display #(
  parameter int WIDTH    = 32,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5,
  output logic [6:0]       hex6,
  output logic [6:0]       hex7,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  // Upper digits come out of reset blank or as "0" depending on blanking mode.
  localparam logic [6:0] SEG_UPPER_RST = BLANK_LZ ? SEG_BLANK : SEG_ZERO;
  localparam logic [4:0] LAST_CNT  = 5'(WIDTH - 1);

  // Active-low seven-segment pattern for one BCD digit; 10..15 go dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [39:0] add3_all(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       bin_sr_q, bin_sr_d;
  logic [39:0]            bcd_sr_q, bcd_sr_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]       shown_val_q, shown_val_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;
  logic [7:0][6:0]        hex_q, hex_d;
  logic [39:0]            bcd_adj;
  logic                   zero_run;
  logic                   ovf_now;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_sr_q    <= '0;
      bcd_sr_q    <= 40'd0;
      cnt_q       <= 5'd0;
      shown_val_q <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      hex_q[0]    <= SEG_ZERO;
      for (int n = 1; n < 8; n++) begin
        hex_q[n] <= SEG_UPPER_RST;
      end
    end else begin
      state_q     <= state_d;
      bin_sr_q    <= bin_sr_d;
      bcd_sr_q    <= bcd_sr_d;
      cnt_q       <= cnt_d;
      shown_val_q <= shown_val_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      hex_q       <= hex_d;
    end
  end

  // Next-state logic: capture on change, shift WIDTH steps, then latch digits.
  always_comb begin
    state_d     = state_q;
    bin_sr_d    = bin_sr_q;
    bcd_sr_d    = bcd_sr_q;
    cnt_d       = cnt_q;
    shown_val_d = shown_val_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    hex_d       = hex_q;
    bcd_adj     = 40'd0;
    zero_run    = 1'b1;
    ovf_now     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gpio_in != shown_val_q) begin
          bin_sr_d    = gpio_in;
          shown_val_d = gpio_in;
          bcd_sr_d    = 40'd0;
          cnt_d       = 5'd0;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_adj  = add3_all(bcd_sr_q);
        bcd_sr_d = {bcd_adj[38:0], bin_sr_q[WIDTH-1]};
        bin_sr_d = {bin_sr_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = LATCH;
        end else begin
          state_d = SHIFT;
        end
      end
      LATCH: begin
        ovf_now  = |bcd_sr_q[39:32];
        hex_d[0] = seg7(bcd_sr_q[3:0]);
        // Walk from the top digit down; a digit blanks while all above are zero.
        for (int n = 7; n >= 1; n--) begin
          zero_run = zero_run & (bcd_sr_q[4*n +: 4] == 4'd0);
          if (BLANK_LZ && !ovf_now && zero_run) begin
            hex_d[n] = SEG_BLANK;
          end else begin
            hex_d[n] = seg7(bcd_sr_q[4*n +: 4]);
          end
        end
        ovf_d   = ovf_now;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_gpio_bcd_display.sv
// Self-checking bench for gpio_bcd_display: directed corner values plus
// random values, compared against a decimal-arithmetic reference model.
module tb_gpio_bcd_display;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio_in;
  logic [6:0]  h0, h1, h2, h3, h4, h5, h6, h7;
  logic        busy;
  logic        ovf;
  logic [6:0]  hex_all [8];

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [10];
  longint unsigned pow10 [10];

  gpio_bcd_display #(.WIDTH(32), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in),
    .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3),
    .hex4(h4), .hex5(h5), .hex6(h6), .hex7(h7),
    .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hex_all[0] = h0;
  assign hex_all[1] = h1;
  assign hex_all[2] = h2;
  assign hex_all[3] = h3;
  assign hex_all[4] = h4;
  assign hex_all[5] = h5;
  assign hex_all[6] = h6;
  assign hex_all[7] = h7;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected segment pattern for digit n of value v, from decimal arithmetic.
  function automatic logic [6:0] model_hex(input longint unsigned v, input int n);
    longint unsigned d;
    d = (v / pow10[n]) % 10;
    if (n >= 1 && v <= 64'd99999999 && v < pow10[n]) return 7'b1111111;
    return seg_tab[d];
  endfunction

  task automatic check_display(input longint unsigned v, input string tag);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("%s_hex%0d", tag, n), {25'd0, hex_all[n]}, {25'd0, model_hex(v, n)});
    end
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, (v > 64'd99999999)});
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Count negedge samples with busy high, starting at the current sample.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic convert(input logic [31:0] v, input string tag);
    int n;
    @(negedge clk);
    gpio_in = v;
    @(negedge clk);
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    count_busy(n);
    check({tag, "_busy_len"}, n, 32'd33);
    check_display({32'd0, v}, tag);
  endtask

  initial begin
    int n;
    logic [31:0] last_v;
    logic [31:0] v;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    pow10[0] = 64'd1;
    for (int i = 1; i < 10; i++) pow10[i] = pow10[i-1] * 10;

    // Reset with zero input: blank display, no conversion afterwards.
    rst_n = 1'b0;
    gpio_in = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_display(64'd0, "reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("reset_no_conv%0d", i), {31'd0, busy}, 32'd0);
    end

    // Directed values.
    convert(32'd1234, "v1234");
    convert(32'd99999999, "v99999999");
    convert(32'd100000000, "v100000000");
    convert(32'hFFFFFFFF, "vFFFFFFFF");

    // Same value held: no new conversion.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("hold_no_conv%0d", i), {31'd0, busy}, 32'd0);
    end

    // Random values across magnitudes so blanking depth varies.
    last_v = 32'hFFFFFFFF;
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: v = $urandom_range(0, 99);
        1: v = $urandom_range(100, 999999);
        2: v = $urandom_range(1000000, 99999999);
        default: v = $urandom;
      endcase
      if (v == last_v) v = v ^ 32'd1;
      convert(v, $sformatf("rnd%0d", i));
      last_v = v;
    end

    // Input change mid-conversion: finish 5, one idle cycle, then convert 7.
    @(negedge clk);
    gpio_in = 32'd5;
    @(negedge clk);
    check("chg_busy_start", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    gpio_in = 32'd7;
    count_busy(n);
    check("chg_first_len", n + 10, 32'd33);
    check_display(64'd5, "chg_first");
    @(negedge clk);
    check("chg_restart", {31'd0, busy}, 32'd1);
    count_busy(n);
    check("chg_second_len", n, 32'd33);
    check_display(64'd7, "chg_second");

    // Reset mid-conversion of 42, then re-conversion after release.
    @(negedge clk);
    gpio_in = 32'd42;
    @(negedge clk);
    check("rst_busy_start", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_display(64'd0, "rst_async");
    @(negedge clk);
    check_display(64'd0, "rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_reconv_start", {31'd0, busy}, 32'd1);
    count_busy(n);
    check("rst_reconv_len", n, 32'd33);
    check_display(64'd42, "rst_reconv");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
